window_max: RTL and testbench
=============================

Name: window_max

Overview:
- Streaming magnitude-tracking stage that consumes unsigned samples and reports the maximum value, plus its position, over each non-overlapping window of N samples.
- Sits downstream of the 4-bit greater-than comparator logic. It applies the same strict a > b decision internally, registered per sample.
- Its result feeds display/LED or bus-interface logic through a valid/ready handshake.

Parameters:
- W, 4, sample width in bits (unsigned).
- N, 8, window length in samples (N >= 2). IW = $clog2(N).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous abort; discards the partial window and any held result
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  W  unsigned sample
- out_valid  output  1  window result is available
- out_ready  input  1  consumer accepts the result
- out_max  output  W  maximum sample of the completed window
- out_idx  output  IW  position (0..N-1) of the first occurrence of out_max within the window
- busy  output  1  at least one sample of the current window has been accepted

Behaviour:
- Interface:
  - One clock.
  - Reset is asynchronous and active-low.
  - Every output and register goes to its reset value immediately when reset_n is low, independent of clk.
- Reset values:
  - in_ready=1, out_valid=0, out_max=0, out_idx=0, busy=0.
  - Internal state ACCUM, count=0.
- State machine, two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept rule: a sample is accepted when in_valid && in_ready at a rising edge.
- Arithmetic, on acceptance in ACCUM:
  - count==0: cur_max<=in_data, cur_idx<=0.
  - count>0 and in_data > cur_max (strict unsigned): cur_max<=in_data, cur_idx<=count.
  - Ties do not update, so the earliest index wins.
  - count increments. There is no wrap-around inside a window.
- Window completion:
  - Accepting the sample with count==N-1 loads out_max/out_idx with the final values, including that sample's comparison.
  - It also sets count<=0 and moves to HOLD.
  - out_valid rises the cycle after the last accept (latency 1).
- HOLD:
  - out_max/out_idx are stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: return to ACCUM, out_valid<=0. in_ready is 1 from the next cycle.
  - No sample is accepted in the cycle the result is consumed.
- busy = (count != 0) in ACCUM; 0 in HOLD.
- out_max/out_idx keep their last values after the handshake until the next window completes.
- clr, when high at a rising edge:
  - Forces ACCUM, count=0, out_valid=0.
  - Any simultaneous in_valid sample is dropped: clr has priority over accept and over the output handshake.
  - out_max/out_idx are unchanged.
- in_valid while in HOLD is ignored; the upstream must hold data per the handshake.
- Reset asserted mid-window or mid-HOLD: the partial window and the held result are lost. After release the block restarts at ACCUM, count=0.

Test Plan (W=4, N=4 unless stated):
1. Reset then idle -> in_ready=1, out_valid=0, out_max=0, out_idx=0, busy=0.
2. Samples 3,9,2,7 back-to-back, out_ready=1 -> out_valid for exactly 1 cycle, one cycle after the 4th accept. out_max=9, out_idx=1. in_ready=1 again the following cycle.
3. Samples 5,F,F,1 with out_ready=0 for 5 cycles -> out_max=F, out_idx=1 held stable with out_valid=1 throughout. in_ready=0, and in_valid pulses during HOLD are not accepted. Raising out_ready completes the handshake.
4. Samples 4,4,4,4 -> out_max=4, out_idx=0 (ties keep the earliest). Samples 0,0,0,8 -> out_max=8, out_idx=3 (last-sample update included).
5. Samples 6,A, then clr=1 together with in_valid=1, data=F; then 1,2,3,2 -> F is dropped, busy=0 after clr. Result is out_max=3, out_idx=2.
6. Assert reset_n=0 asynchronously after 2 of 4 samples, and again while in HOLD -> outputs return to reset values without a clock edge. Window 8,1,1,1 after release gives out_max=8, out_idx=0.

Source files
------------

// File: rtl/window_max.sv
// Streaming window maximum: reports the largest unsigned sample, and the index of its
// first occurrence, over each non-overlapping window of N samples via valid/ready.
module window_max #(
  parameter int W = 4,
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_max,
  output logic [IW-1:0] out_idx,
  output logic          busy
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state, state_next;
  logic [IW-1:0] count;
  logic [W-1:0]  cur_max;
  logic [IW-1:0] cur_idx;
  logic [W-1:0]  cand_max;
  logic [IW-1:0] cand_idx;
  logic          accept;
  logic          last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state == ACCUM) && (count != '0);
  assign accept    = in_valid && in_ready;
  assign last      = (count == LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last) state_next = HOLD;
        HOLD:    if (out_ready)      state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  // Strict compare: a tie keeps the earlier index.
  always_comb begin
    cand_max = cur_max;
    cand_idx = cur_idx;
    if (count == '0) begin
      cand_max = in_data;
      cand_idx = '0;
    end else if (in_data > cur_max) begin
      cand_max = in_data;
      cand_idx = count;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // clr discards the partial window but leaves the last reported result visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      cur_max <= '0;
      cur_idx <= '0;
      out_max <= '0;
      out_idx <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (accept) begin
      cur_max <= cand_max;
      cur_idx <= cand_idx;
      if (last) begin
        count   <= '0;
        out_max <= cand_max;
        out_idx <= cand_idx;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_window_max.sv
// Scoreboard bench for window_max (W=4, N=4): stimulus queues expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_window_max;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  max;
    logic [IW-1:0] idx;
  } res_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic          busy;

  int   vectors = 0;
  int   miscompares = 0;
  res_t exp_q[$];

  window_max #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_max"},   32'(out_max),   32'd0);
    check({tag, "_out_idx"},   32'(out_idx),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // One sample per cycle; inputs change 1ns after the active edge.
  task automatic send(input logic [W-1:0] d);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  // Called right after the last accept with out_ready=1: result shows for exactly one cycle.
  task automatic finish_window();
    check("out_valid_after_last", 32'(out_valid), 32'd1);
    check("in_ready_in_hold",     32'(in_ready),  32'd0);
    @(posedge clk); #1;
    check("out_valid_one_cycle",  32'(out_valid), 32'd0);
    check("in_ready_after_hs",    32'(in_ready),  32'd1);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got max %0h idx %0d with nothing expected", out_max, out_idx);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sb_out_max", 32'(out_max), 32'(e.max));
        check("sb_out_idx", 32'(out_idx), 32'(e.idx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset then idle
    #1 check_reset_values("reset_async");
    #11 reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_values("idle");

    // 2. 3,9,2,7 with out_ready=1
    out_ready = 1'b1;
    exp_q.push_back('{max: 4'h9, idx: 2'd1});
    send4(4'h3, 4'h9, 4'h2, 4'h7);
    check("busy_in_hold", 32'(busy), 32'd0);
    finish_window();

    // 3. 5,F,F,1 held with out_ready=0; in_valid pulses during HOLD are ignored
    out_ready = 1'b0;
    send4(4'h5, 4'hF, 4'hF, 4'h1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 4'h3;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      check("hold_out_max",   32'(out_max),   32'hF);
      check("hold_out_idx",   32'(out_idx),   32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_q.push_back('{max: 4'hF, idx: 2'd1});
    out_ready = 1'b1;
    finish_window();
    check("busy_after_hold_pulses", 32'(busy), 32'd0);

    // 4. Ties keep earliest; last sample's comparison is included
    exp_q.push_back('{max: 4'h4, idx: 2'd0});
    send4(4'h4, 4'h4, 4'h4, 4'h4);
    finish_window();
    exp_q.push_back('{max: 4'h8, idx: 2'd3});
    send4(4'h0, 4'h0, 4'h0, 4'h8);
    finish_window();

    // 5. clr with a simultaneous sample drops it and the partial window
    send(4'h6);
    send(4'hA);
    check("busy_mid_window", 32'(busy), 32'd1);
    clr = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_busy",      32'(busy),      32'd0);
    check("clr_in_ready",  32'(in_ready),  32'd1);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_out_max",   32'(out_max),   32'h8);
    check("clr_out_idx",   32'(out_idx),   32'd3);
    exp_q.push_back('{max: 4'h3, idx: 2'd2});
    send4(4'h1, 4'h2, 4'h3, 4'h2);
    finish_window();

    // clr during HOLD discards the held result but keeps out_max/out_idx
    out_ready = 1'b0;
    send4(4'h9, 4'h9, 4'h9, 4'h9);
    check("pre_clr_hold_valid", 32'(out_valid), 32'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_hold_out_valid", 32'(out_valid), 32'd0);
    check("clr_hold_in_ready",  32'(in_ready),  32'd1);
    check("clr_hold_out_max",   32'(out_max),   32'h9);
    check("clr_hold_out_idx",   32'(out_idx),   32'd0);

    // 6. Asynchronous reset mid-window and mid-HOLD
    send(4'h2);
    send(4'h5);
    #2 reset_n = 1'b0;
    #1 check_reset_values("rst_mid_window");
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    send4(4'h5, 4'h6, 4'h7, 4'h8);
    check("pre_rst_hold_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("rst_mid_hold");
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back('{max: 4'h8, idx: 2'd0});
    send4(4'h8, 4'h1, 4'h1, 4'h1);
    finish_window();

    @(posedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
